// File: rtl/adder_arb_pkg.sv
// adder_arb_pkg: shared types, default sizes and helpers for the adder
// arbiter slice.
//   arb_state_t : sequencer state (IDLE -> CALC -> RESP)
//   DEF_WIDTH   : default operand/result width
//   DEF_N       : default requester count
//   rr_next()   : round-robin pointer advance with wrap to 0
package adder_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_N     = 4;

    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/adder_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority picker.
// Scans req starting at ptr, wrapping modulo N, and returns the first hit.
// Ports:
//   req  [N-1:0]    : request vector
//   ptr  [ID_W-1:0] : index with highest priority this cycle (always < N)
//   gnt  [N-1:0]    : one-hot grant (all zero when nothing requests)
//   idx  [ID_W-1:0] : encoded grant index (0 when nothing requests)
//   any             : at least one request present
module rr_pick #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] idx,
    output logic            any
);

    logic [ID_W-1:0] pos;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        pos = '0;
        for (int k = 0; k < N; k++) begin
            pos = ID_W'((int'(ptr) + k) % N);
            if (!any && req[pos]) begin
                any      = 1'b1;
                gnt[pos] = 1'b1;
                idx      = pos;
            end
        end
    end

endmodule

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin sequencer sharing one external WIDTH-bit adder
// among N requesters. One op in flight: grant -> CALC (adder sees registered
// operands) -> RESP (sum held until consumed). A response handshake may grant
// the next request in the same cycle, giving one op per 2 cycles.
// Optional feature macro: ADDER_ARB_STATS_EN adds stat_grants, a saturating
// 16-bit count of completed request handshakes.
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   req_valid/req_ready   : per-requester handshake (req_ready one-hot/zero)
//   req_a, req_b          : packed operands, requester i at [i*WIDTH +: WIDTH]
//   add_a, add_b, add_y   : to/from the shared adder (add_a/add_b registered)
//   rsp_valid/rsp_ready   : response handshake
//   rsp_y, rsp_id         : registered sum and owning requester index
//   stat_grants           : grant counter (ADDER_ARB_STATS_EN only)
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N     = DEF_N,
    parameter int ID_W  = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req_valid,
    output logic [N-1:0]         req_ready,
    input  logic [N*WIDTH-1:0]   req_a,
    input  logic [N*WIDTH-1:0]   req_b,
    output logic [WIDTH-1:0]     add_a,
    output logic [WIDTH-1:0]     add_b,
    input  logic [WIDTH-1:0]     add_y,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [WIDTH-1:0]     rsp_y,
    output logic [ID_W-1:0]      rsp_id
`ifdef ADDER_ARB_STATS_EN
    ,
    output logic [15:0]          stat_grants
`endif
);

    arb_state_t state, state_nxt;

    logic [N-1:0][WIDTH-1:0] a_v, b_v;
    logic [WIDTH-1:0]        a_q, b_q;
    logic [ID_W-1:0]         rr_ptr, id_q, g_idx;
    logic [N-1:0]            g_hot;
    logic                    g_any, grant_en, take;

    assign a_v   = req_a;
    assign b_v   = req_b;
    assign add_a = a_q;
    assign add_b = b_q;

    rr_pick #(.N(N), .ID_W(ID_W)) u_pick (
        .req (req_valid),
        .ptr (rr_ptr),
        .gnt (g_hot),
        .idx (g_idx),
        .any (g_any)
    );

    // Grants are offered from IDLE, or from RESP in the cycle the response
    // is consumed (bypass). rst_n gates req_ready so nothing handshakes
    // while reset is held.
    always_comb begin
        grant_en  = rst_n && ((state == IDLE) || ((state == RESP) && rsp_ready));
        req_ready = grant_en ? g_hot : '0;
        take      = grant_en && g_any;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (g_any) state_nxt = CALC;
            CALC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = g_any ? CALC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            id_q      <= '0;
            rsp_y     <= '0;
            rsp_id    <= '0;
            rsp_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            if (take) begin
                a_q    <= a_v[g_idx];
                b_q    <= b_v[g_idx];
                id_q   <= g_idx;
                rr_ptr <= ID_W'(rr_next(32'(g_idx), N));
            end
            if (state == CALC) begin
                rsp_y     <= add_y;
                rsp_id    <= id_q;
                rsp_valid <= 1'b1;
            end else if ((state == RESP) && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

`ifdef ADDER_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stat_grants <= '0;
        else if (take && (stat_grants != 16'hFFFF))
            stat_grants <= stat_grants + 16'd1;
    end
`endif

endmodule
